// File: rtl/arbitro_restador_if.sv
// Request/result bundle between the PWM requesters and the shared subtractor arbiter.
// Requesters drive the master side; the arbiter is the slave.
interface arbitro_restador_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               res_valid;
  logic [2:0]         res_id;
  logic [W-1:0]       res_data;
  logic               res_borrow;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, res_valid,
    input  res_id, res_data, res_borrow
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, res_valid,
    output res_id, res_data, res_borrow
  );
endinterface

// File: rtl/arbitro_restador.sv
// Round-robin arbiter sharing one ripple subtractor among N_REQ requesters.
// Define RESTA_SAT_EN to clamp negative differences to 0 (borrow still reported).
module arbitro_restador #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input logic               clk,
  input logic               rst_n,
  arbitro_restador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_ptr;
  logic [2:0]       r_sel;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [N_REQ-1:0] r_gnt;
  logic             r_res_valid;
  logic [2:0]       r_res_id;
  logic [W-1:0]     r_res_data;
  logic             r_res_borrow;

  logic             w_hit;
  logic [2:0]       w_pick;
  int               w_best;
  int               w_dist;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [N_REQ-1:0] w_oh;
  logic [W-1:0]     w_diff;
  logic [W:0]       w_bw;
  logic [W-1:0]     w_out;

  // Distance 0 is the requester right after the last one served.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_ptr;
    w_best = N_REQ;
    w_dist = 0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = (j + 2 * N_REQ - 1 - int'(r_ptr)) % N_REQ;
      if (bus.req[j] && (w_dist < w_best)) begin
        w_hit  = 1'b1;
        w_best = w_dist;
        w_pick = 3'(j);
      end
    end
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_oh = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_pick == 3'(j)) begin
        w_a     = bus.a_in[j*W +: W];
        w_b     = bus.b_in[j*W +: W];
        w_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_bw[0] = 1'b0;
    w_diff  = '0;
    for (int i = 0; i < W; i++) begin
      w_diff[i]  = r_a[i] ^ r_b[i] ^ w_bw[i];
      w_bw[i+1]  = (~r_a[i] & r_b[i])
                 | (~(r_a[i] ^ r_b[i]) & w_bw[i]);
    end
  end

`ifdef RESTA_SAT_EN
  assign w_out = w_bw[W] ? '0 : w_diff;
`else
  assign w_out = w_diff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hit) w_next = SUB;
      SUB:     w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= 3'(N_REQ - 1);
      r_sel        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_gnt        <= '0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_data   <= '0;
      r_res_borrow <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_res_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_sel <= w_pick;
            r_a   <= w_a;
            r_b   <= w_b;
            r_gnt <= w_oh;
          end
        end
        SUB: begin
          r_res_data   <= w_out;
          r_res_borrow <= w_bw[W];
          r_res_id     <= r_sel;
          r_res_valid  <= 1'b1;
        end
        RESP:    r_ptr <= r_sel;
        default: ;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.busy       = (r_state != IDLE);
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_data   = r_res_data;
  assign bus.res_borrow = r_res_borrow;

endmodule
